// File: rtl/mini_alu_exec_pkg.sv
// Shared definitions for the mini ALU execute stage: opcodes, FSM states, return-address register.
// Opcode values are fixed by the decoder; keep them in sync with it.
package mini_alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_STO  = 4'd4,
    OP_BLE  = 4'd5,
    OP_JMP  = 4'd6,
    OP_CALL = 4'd7,
    OP_RET  = 4'd8,
    OP_PUSH = 4'd9,
    OP_POP  = 4'd10,
    OP_OUT  = 4'd11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_PWAIT = 2'd2
  } state_e;

  // Register that CALL writes the return address into.
  localparam int RA_ADDR = 15;

endpackage

// File: rtl/mini_alu_stack.sv
// Parametrised LIFO, synchronous reset; push/pop take effect on the clock edge, top is combinational.
// Push when full and pop when empty are ignored here; the caller flags the error.
module mini_alu_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] top
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       sp;
  logic [AW-1:0]     top_idx;

  assign full    = (sp == (AW+1)'(DEPTH));
  assign empty   = (sp == '0);
  // When full the low bits wrap to zero, so this still points at the last entry.
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mini_alu_exec.sv
// Execute stage: ALU, branches, CALL/RET, LIFO and handshaked peripheral writes; results one cycle after accept.
// oReady drops while an iterative MUL runs or an OUT waits for its channel's ready.
module mini_alu_exec
  import mini_alu_exec_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 8,
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 16,
  parameter int NUM_PERIPH  = 4,
  parameter int MUL_ITER    = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [3:0]            iOpcode,
  input  logic [RADDR_W-1:0]    iDest,
  input  logic [DATA_W-1:0]     iSrcData0,
  input  logic [DATA_W-1:0]     iSrcData1,
  input  logic [DATA_W-1:0]     iImm,
  input  logic [PC_W-1:0]       iPC,
  output logic                  oRegWe,
  output logic [RADDR_W-1:0]    oRegWAddr,
  output logic [DATA_W-1:0]     oRegWData,
  output logic                  oRedirect,
  output logic [PC_W-1:0]       oRedirectPC,
  output logic [NUM_PERIPH-1:0] oPeriphValid,
  output logic [DATA_W-1:0]     oPeriphAddr,
  output logic [DATA_W-1:0]     oPeriphData,
  input  logic [NUM_PERIPH-1:0] iPeriphReady,
  output logic [1:0]            oStackErr
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_e             state;
  opcode_e            op;
  logic               accept;
  logic [3:0]         ch;
  logic               ch_ok;
  logic               stk_full;
  logic               stk_empty;
  logic [DATA_W-1:0]  stk_top;
  logic [DATA_W-1:0]  mul_prod;
  logic [DATA_W-1:0]  mcand;
  logic [DATA_W-1:0]  mplier;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]   mul_cnt;
  logic [RADDR_W-1:0] mul_dest;

  assign op       = opcode_e'(iOpcode);
  assign oReady   = (state == ST_IDLE);
  assign accept   = iValid && oReady;
  assign ch       = iDest[3:0];
  assign ch_ok    = ({28'd0, ch} < 32'(NUM_PERIPH));
  assign mul_prod = iSrcData0 * iSrcData1;
  assign acc_nxt  = mplier[0] ? acc + mcand : acc;

  mini_alu_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (Clock),
    .reset     (Reset),
    .push      (accept && (op == OP_PUSH)),
    .pop       (accept && (op == OP_POP)),
    .push_data (iSrcData0),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      oRegWe       <= 1'b0;
      oRegWAddr    <= '0;
      oRegWData    <= '0;
      oRedirect    <= 1'b0;
      oRedirectPC  <= '0;
      oPeriphValid <= '0;
      oPeriphAddr  <= '0;
      oPeriphData  <= '0;
      oStackErr    <= 2'b00;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      mul_cnt      <= '0;
      mul_dest     <= '0;
    end else begin
      oRegWe    <= 1'b0;
      oRedirect <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iValid) begin
            case (op)
              OP_ADD: begin
                oRegWe    <= 1'b1;
                oRegWAddr <= iDest;
                oRegWData <= iSrcData0 + iSrcData1;
              end
              OP_SUB: begin
                oRegWe    <= 1'b1;
                oRegWAddr <= iDest;
                oRegWData <= iSrcData0 - iSrcData1;
              end
              OP_MUL: begin
                if (MUL_ITER != 0) begin
                  state    <= ST_MULT;
                  mcand    <= iSrcData0;
                  mplier   <= iSrcData1;
                  acc      <= '0;
                  mul_cnt  <= '0;
                  mul_dest <= iDest;
                end else begin
                  oRegWe    <= 1'b1;
                  oRegWAddr <= iDest;
                  oRegWData <= mul_prod;
                end
              end
              OP_STO: begin
                oRegWe    <= 1'b1;
                oRegWAddr <= iDest;
                oRegWData <= iImm;
              end
              OP_BLE: begin
                if (iSrcData1 <= iSrcData0) begin
                  oRedirect   <= 1'b1;
                  oRedirectPC <= PC_W'(iDest);
                end
              end
              OP_JMP: begin
                oRedirect   <= 1'b1;
                oRedirectPC <= PC_W'(iDest);
              end
              OP_CALL: begin
                oRegWe      <= 1'b1;
                oRegWAddr   <= RADDR_W'(RA_ADDR);
                oRegWData   <= DATA_W'(iPC);
                oRedirect   <= 1'b1;
                oRedirectPC <= PC_W'(iDest);
              end
              OP_RET: begin
                oRedirect   <= 1'b1;
                oRedirectPC <= PC_W'(iSrcData0);
              end
              OP_PUSH: begin
                if (stk_full) oStackErr[1] <= 1'b1;
              end
              OP_POP: begin
                oRegWe    <= 1'b1;
                oRegWAddr <= iDest;
                oRegWData <= stk_empty ? '0 : stk_top;
                if (stk_empty) oStackErr[0] <= 1'b1;
              end
              OP_OUT: begin
                // Channels beyond NUM_PERIPH are dropped without stalling.
                if (ch_ok) begin
                  state        <= ST_PWAIT;
                  oPeriphValid <= NUM_PERIPH'(1) << ch;
                  oPeriphAddr  <= iSrcData0;
                  oPeriphData  <= iSrcData1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MULT: begin
          acc     <= acc_nxt;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + CNT_W'(1);
          if (mul_cnt == CNT_W'(DATA_W - 1)) begin
            state     <= ST_IDLE;
            oRegWe    <= 1'b1;
            oRegWAddr <= mul_dest;
            oRegWData <= acc_nxt;
          end
        end
        ST_PWAIT: begin
          // Valid is one-hot, so this is the ready of the active channel only.
          if (|(oPeriphValid & iPeriphReady)) begin
            state        <= ST_IDLE;
            oPeriphValid <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu_exec.sv
// Directed bench for mini_alu_exec with default parameters; expected values are hand-computed.
module tb_mini_alu_exec;
  import mini_alu_exec_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iValid;
  logic        oReady;
  logic [3:0]  iOpcode;
  logic [7:0]  iDest;
  logic [15:0] iSrcData0;
  logic [15:0] iSrcData1;
  logic [15:0] iImm;
  logic [15:0] iPC;
  logic        oRegWe;
  logic [7:0]  oRegWAddr;
  logic [15:0] oRegWData;
  logic        oRedirect;
  logic [15:0] oRedirectPC;
  logic [3:0]  oPeriphValid;
  logic [15:0] oPeriphAddr;
  logic [15:0] oPeriphData;
  logic [3:0]  iPeriphReady;
  logic [1:0]  oStackErr;

  int total = 0;
  int bad   = 0;

  mini_alu_exec dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iValid       (iValid),
    .oReady       (oReady),
    .iOpcode      (iOpcode),
    .iDest        (iDest),
    .iSrcData0    (iSrcData0),
    .iSrcData1    (iSrcData1),
    .iImm         (iImm),
    .iPC          (iPC),
    .oRegWe       (oRegWe),
    .oRegWAddr    (oRegWAddr),
    .oRegWData    (oRegWData),
    .oRedirect    (oRedirect),
    .oRedirectPC  (oRedirectPC),
    .oPeriphValid (oPeriphValid),
    .oPeriphAddr  (oPeriphAddr),
    .oPeriphData  (oPeriphData),
    .iPeriphReady (iPeriphReady),
    .oStackErr    (oStackErr)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, where the registered results are visible.
  task automatic issue(input logic [3:0] op, input logic [7:0] dest, input logic [15:0] s0,
                       input logic [15:0] s1, input logic [15:0] imm, input logic [15:0] pc);
    iOpcode   = op;
    iDest     = dest;
    iSrcData0 = s0;
    iSrcData1 = s1;
    iImm      = imm;
    iPC       = pc;
    iValid    = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    iValid = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    int we_seen;
    Reset        = 1'b1;
    iValid       = 1'b0;
    iOpcode      = 4'd0;
    iDest        = 8'd0;
    iSrcData0    = 16'd0;
    iSrcData1    = 16'd0;
    iImm         = 16'd0;
    iPC          = 16'd0;
    iPeriphReady = 4'b0000;
    @(negedge Clock);
    do_reset();

    check("rst_ready",   32'(oReady), 32'd1);
    check("rst_we",      32'(oRegWe), 32'd0);
    check("rst_wdata",   32'(oRegWData), 32'd0);
    check("rst_redir",   32'(oRedirect), 32'd0);
    check("rst_pvalid",  32'(oPeriphValid), 32'd0);
    check("rst_err",     32'(oStackErr), 32'd0);

    issue(OP_ADD, 8'd3, 16'hFFFF, 16'h0002, 16'h0, 16'h0);
    check("add_we",    32'(oRegWe), 32'd1);
    check("add_addr",  32'(oRegWAddr), 32'd3);
    check("add_data",  32'(oRegWData), 32'h0001);
    @(negedge Clock);
    check("add_we_1cyc", 32'(oRegWe), 32'd0);

    issue(OP_SUB, 8'd4, 16'h0002, 16'h0005, 16'h0, 16'h0);
    check("sub_data",  32'(oRegWData), 32'hFFFD);
    issue(OP_STO, 8'd6, 16'h0, 16'h0, 16'h1234, 16'h0);
    check("sto_addr",  32'(oRegWAddr), 32'd6);
    check("sto_data",  32'(oRegWData), 32'h1234);
    issue(OP_NOP, 8'd1, 16'h1, 16'h1, 16'h1, 16'h1);
    check("nop_we",    32'(oRegWe), 32'd0);
    check("nop_redir", 32'(oRedirect), 32'd0);
    issue(4'd15, 8'd1, 16'h1, 16'h1, 16'h1, 16'h1);
    check("undef_we",  32'(oRegWe), 32'd0);
    check("undef_redir", 32'(oRedirect), 32'd0);

    // 300*300 = 90000 = 0x15F90
    issue(OP_MUL, 8'd7, 16'd300, 16'd300, 16'h0, 16'h0);
    n = 0;
    for (int i = 0; i < 40 && !oRegWe; i++) begin
      if (!oReady) n++;
      @(negedge Clock);
    end
    check("mul_busy_cycles", 32'(n), 32'd16);
    check("mul_we",    32'(oRegWe), 32'd1);
    check("mul_addr",  32'(oRegWAddr), 32'd7);
    check("mul_data",  32'(oRegWData), 32'h5F90);
    check("mul_ready", 32'(oReady), 32'd1);

    issue(OP_CALL, 8'h20, 16'h0, 16'h0, 16'h0, 16'h0005);
    check("call_we",    32'(oRegWe), 32'd1);
    check("call_addr",  32'(oRegWAddr), 32'd15);
    check("call_data",  32'(oRegWData), 32'h0005);
    check("call_redir", 32'(oRedirect), 32'd1);
    check("call_pc",    32'(oRedirectPC), 32'h0020);
    issue(OP_RET, 8'h0, 16'h0005, 16'h0, 16'h0, 16'h0);
    check("ret_redir",  32'(oRedirect), 32'd1);
    check("ret_pc",     32'(oRedirectPC), 32'h0005);
    check("ret_we",     32'(oRegWe), 32'd0);
    issue(OP_BLE, 8'h40, 16'd7, 16'd3, 16'h0, 16'h0);
    check("ble_lt_redir", 32'(oRedirect), 32'd1);
    check("ble_lt_pc",    32'(oRedirectPC), 32'h0040);
    issue(OP_BLE, 8'h41, 16'd7, 16'd7, 16'h0, 16'h0);
    check("ble_eq_pc",    32'(oRedirectPC), 32'h0041);
    check("ble_eq_redir", 32'(oRedirect), 32'd1);
    issue(OP_BLE, 8'h42, 16'd7, 16'd8, 16'h0, 16'h0);
    check("ble_gt_redir", 32'(oRedirect), 32'd0);
    issue(OP_BLE, 8'h43, 16'h8000, 16'hFFFF, 16'h0, 16'h0);
    check("ble_unsigned", 32'(oRedirect), 32'd0);
    issue(OP_JMP, 8'h11, 16'h0, 16'h0, 16'h0, 16'h0);
    check("jmp_pc",       32'(oRedirectPC), 32'h0011);

    for (int i = 1; i <= 17; i++) begin
      issue(OP_PUSH, 8'd0, 16'(i), 16'h0, 16'h0, 16'h0);
      if (i == 16) check("push16_err", 32'(oStackErr), 32'b00);
      check("push_we", 32'(oRegWe), 32'd0);
    end
    check("push17_err", 32'(oStackErr), 32'b10);
    for (int i = 16; i >= 0; i--) begin
      issue(OP_POP, 8'd9, 16'h0, 16'h0, 16'h0, 16'h0);
      check("pop_we",   32'(oRegWe), 32'd1);
      check("pop_data", 32'(oRegWData), 32'(i));
      if (i == 1) check("pop16_err", 32'(oStackErr), 32'b10);
    end
    check("pop17_err", 32'(oStackErr), 32'b11);
    issue(OP_ADD, 8'd3, 16'h1, 16'h1, 16'h0, 16'h0);
    check("err_sticky", 32'(oStackErr), 32'b11);

    iPeriphReady = 4'b0000;
    issue(OP_OUT, 8'd2, 16'hA5A5, 16'h5A5A, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      check("out_wait_valid", 32'(oPeriphValid), 32'b0100);
      check("out_wait_addr",  32'(oPeriphAddr), 32'hA5A5);
      check("out_wait_data",  32'(oPeriphData), 32'h5A5A);
      check("out_wait_ready", 32'(oReady), 32'd0);
      // Ready on other channels must not release channel 2.
      iPeriphReady = 4'b1011;
      @(negedge Clock);
    end
    iPeriphReady = 4'b0100;
    @(negedge Clock);
    iPeriphReady = 4'b0000;
    check("out_done_valid", 32'(oPeriphValid), 32'd0);
    check("out_done_ready", 32'(oReady), 32'd1);

    iPeriphReady = 4'b0010;
    issue(OP_OUT, 8'd1, 16'h0011, 16'h0022, 16'h0, 16'h0);
    check("out1_valid", 32'(oPeriphValid), 32'b0010);
    @(negedge Clock);
    check("out1_release", 32'(oPeriphValid), 32'd0);
    check("out1_ready",   32'(oReady), 32'd1);
    iPeriphReady = 4'b0000;

    issue(OP_OUT, 8'd7, 16'h0011, 16'h0022, 16'h0, 16'h0);
    check("out_badch_valid", 32'(oPeriphValid), 32'd0);
    check("out_badch_ready", 32'(oReady), 32'd1);

    issue(OP_MUL, 8'd5, 16'd300, 16'd300, 16'h0, 16'h0);
    repeat (3) @(negedge Clock);
    do_reset();
    check("rst_mul_ready", 32'(oReady), 32'd1);
    check("rst_mul_err",   32'(oStackErr), 32'd0);
    we_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (oRegWe) we_seen++;
      @(negedge Clock);
    end
    check("rst_mul_no_we", 32'(we_seen), 32'd0);

    issue(OP_OUT, 8'd3, 16'h0033, 16'h0044, 16'h0, 16'h0);
    check("pwait_valid", 32'(oPeriphValid), 32'b1000);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("rst_pwait_valid", 32'(oPeriphValid), 32'd0);
    check("rst_pwait_ready", 32'(oReady), 32'd1);
    check("rst_pwait_we",    32'(oRegWe), 32'd0);

    issue(OP_POP, 8'd2, 16'h0, 16'h0, 16'h0, 16'h0);
    check("rst_stack_empty", 32'(oRegWData), 32'd0);
    check("rst_stack_err",   32'(oStackErr), 32'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
